fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the MIPS pipeline: owns the PC, runs the request/acknowledge handshake with instruction memory, and drives the IF/ID pipeline register's `instruction`, `awrite` and `aclr` inputs. It absorbs ID-stage stalls by buffering one fetched word. It applies branch and jump redirects by flushing IF/ID with a bubble, and inserts bubbles whenever no valid instruction is available. Memory latency is variable; zero-wait memory (`imem_ack` tied high) sustains one instruction per cycle.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request; address must stay stable while high and unacknowledged
- `imem_addr`  out  32  fetch address (current PC)
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; same-cycle ack allowed
- `imem_rdata`  in  32  fetched word, valid only with `imem_ack`
- `stall`  in  1  ID cannot accept a new instruction (load-use); IF/ID must hold
- `branch_taken`  in  1  resolved taken branch from a later stage
- `branch_target`  in  32  branch destination
- `jump`  in  1  J-type instruction currently in ID
- `jump_index`  in  26  instruction[25:0] from IF/ID
- `instruction`  out  32  word presented to IF/ID
- `awrite`  out  1  IF/ID write enable
- `aclr`  out  1  IF/ID clear (loads bubble opcode 6'b111111)
- `id_pc_plus4`  out  32  PC+4 of the instruction in IF/ID, registered alongside it

## Operation
- States: REQ (request outstanding), HOLD (word buffered, waiting for stall to drop), DROP (redirect arrived mid-request; wait for ack, then discard).
- Redirect = `branch_taken | jump`. Target: branch_target if `branch_taken`, else {id_pc_plus4[31:28], jump_index, 2'b00`}. `branch_taken` wins over `jump`.
- `imem_req` = 1 in REQ and DROP; `imem_addr` = PC.
- REQ, ack, no redirect, no stall: deliver `imem_rdata` (awrite=1, aclr=0). PC <= PC+4. id_pc_plus4 <= PC+4. Stay in REQ.
- REQ, ack, stall, no redirect: hold_buf <= imem_rdata, hold_pc4 <= PC+4, PC <= PC+4. Go to HOLD. awrite=0.
- REQ, no ack, no redirect: awrite=stall?0:1, aclr=1 (bubble when not stalled).
- HOLD, no stall, no redirect: deliver hold_buf (awrite=1, aclr=0). id_pc_plus4 <= hold_pc4. Go to REQ.
- HOLD, stall: awrite=0. Remain in HOLD.
- Redirect, in any state: awrite=1, aclr=1, regardless of stall; the flush overrides the stall.
  - REQ with ack, or HOLD: PC <= target; go to (or stay in) REQ.
  - REQ without ack: redir_pc <= target; go to DROP.
  - DROP: redir_pc <= newest target.
- DROP, ack: discard the word. PC <= redir_pc. Go to REQ. Bubble unless stalled.
- DROP, no ack: bubble unless stalled.
- PC arithmetic is 32-bit with wrap-around; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (async assert): PC=RESET_PC, state=REQ, redir_pc=0, hold_buf=0, id_pc_plus4=0.
- While `rst_n` is low: imem_req=0, awrite=1, aclr=1. IF/ID therefore loads a bubble on each clock during reset.
- First request is the cycle after `rst_n` deasserts.
- `awrite`, `aclr`, `instruction`, `imem_req`, `imem_addr` are combinational from state, registers and inputs. With zero-wait memory, fetch-to-IF/ID latency is 1 edge.
- Redirect penalty: the flush edge plus the memory latency of the target fetch. With zero-wait memory, the target is in IF/ID 1 edge after the flush edge.
- Reset asserted mid-request: the outstanding request is abandoned; memory must tolerate a dropped request.

## Structure
- Package `mips_fetch_pkg`: state enum {REQ, HOLD, DROP}, BUBBLE_OPCODE 6'b111111, PC_INC 32'd4.
- Single module; no sub-module needed.

## Test plan
- imem_ack tied 1, RESET_PC=0: after reset, IF/ID receives addresses 0,4,8,... one per cycle; id_pc_plus4=4,8,12.
- Ack delayed 2 cycles: two bubble cycles (awrite=1, aclr=1), then the word is delivered; imem_addr stays stable while waiting.
- stall high for 3 cycles on an ack cycle: awrite=0 for 3 cycles, then the buffered word is delivered with correct id_pc_plus4, with no re-fetch.
- branch_taken with target 0x40 while a request is outstanding: flush that cycle, the late word is discarded, and the next request is issued to 0x40.
- jump with id_pc_plus4=0x1000_0008 and jump_index=0x10: flush, and the next imem_addr is 0x1000_0040. Asserting branch_taken together with jump selects branch_target instead.
- rst_n pulsed low mid-HOLD: outputs immediately return to their reset values, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// mips_fetch_pkg: shared constants for the MIPS instruction-fetch stage.
//   - FSM state encodings (REQ / HOLD / DROP)
//   - BUBBLE_OPCODE: opcode the IF/ID register loads when cleared
//   - PC_INC: sequential PC step
package mips_fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_REQ  = 2'd0;  // request outstanding to instruction memory
  localparam state_t ST_HOLD = 2'd1;  // fetched word buffered, waiting for stall to drop
  localparam state_t ST_DROP = 2'd2;  // redirect arrived mid-request; discard the late word

  localparam logic [5:0]  BUBBLE_OPCODE = 6'b111111;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: request/acknowledge bus between the fetch stage and
// instruction memory.
//   imem_req   fetch request; address held stable until acknowledged
//   imem_addr  fetch address
//   imem_ack   memory returns imem_rdata this cycle (same-cycle ack allowed)
//   imem_rdata fetched word, valid only with imem_ack
// Modports: master = fetch stage, slave = memory.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the MIPS pipeline. Owns the PC, handshakes with
// instruction memory, and drives the IF/ID register (instruction/awrite/aclr).
// One fetched word is buffered to ride out ID stalls; branch/jump redirects
// flush IF/ID with a bubble.
//   clk, rst_n      clock, asynchronous active-low reset
//   imem            instruction memory bus (master side)
//   stall           ID cannot accept a new instruction; IF/ID holds
//   branch_taken    resolved taken branch, target on branch_target
//   jump            J-type in ID, index on jump_index
//   instruction     word presented to IF/ID
//   awrite, aclr    IF/ID write enable / clear-to-bubble
//   id_pc_plus4     PC+4 of the instruction sitting in IF/ID
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  output logic [31:0]        instruction,
  output logic               awrite,
  output logic               aclr,
  output logic [31:0]        id_pc_plus4
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic [31:0] hold_buf;
  logic [31:0] hold_pc4;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_next_seq;
  logic        use_hold;

  assign redirect    = branch_taken | jump;
  // branch_taken has priority: it comes from a later, older instruction.
  assign target      = branch_taken ? branch_target
                                    : {id_pc_plus4[31:28], jump_index, 2'b00};
  assign pc_next_seq = pc + PC_INC;  // 32-bit wrap-around is intended

  // Gated with rst_n so no request escapes while reset is held.
  assign imem.imem_req  = rst_n && ((state == ST_REQ) || (state == ST_DROP));
  assign imem.imem_addr = pc;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    awrite   = 1'b0;
    aclr     = 1'b0;
    use_hold = 1'b0;
    if (!rst_n || redirect) begin
      // Flush overrides stall: the wrong-path instruction must leave IF/ID.
      awrite = 1'b1;
      aclr   = 1'b1;
    end else begin
      case (state)
        ST_REQ: begin
          awrite = !stall;
          aclr   = !imem.imem_ack;  // nothing arrived: bubble
        end
        ST_HOLD: begin
          awrite   = !stall;
          use_hold = 1'b1;
        end
        default: begin  // ST_DROP: the word in flight is wrong-path
          awrite = !stall;
          aclr   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    if (aclr)          instruction = {BUBBLE_OPCODE, 26'b0};
    else if (use_hold) instruction = hold_buf;
    else               instruction = imem.imem_rdata;
  end

  // NOTE: every state register is reset so the stage restarts from a known
  // PC regardless of where a request was abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      redir_pc    <= '0;
      hold_buf    <= '0;
      hold_pc4    <= '0;
      id_pc_plus4 <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      case (state)
        ST_REQ: begin
          if (redirect) begin
            if (imem.imem_ack) begin
              pc <= target;
            end else begin
              // Request is in flight and its address must stay stable:
              // park the target until memory answers.
              redir_pc <= target;
              state    <= ST_DROP;
            end
          end else if (imem.imem_ack) begin
            pc <= pc_next_seq;
            if (stall) begin
              hold_buf <= imem.imem_rdata;
              hold_pc4 <= pc_next_seq;
              state    <= ST_HOLD;
            end else begin
              id_pc_plus4 <= pc_next_seq;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= ST_REQ;
          end else if (!stall) begin
            id_pc_plus4 <= hold_pc4;
            state       <= ST_REQ;
          end
        end
        default: begin  // ST_DROP
          if (imem.imem_ack) begin
            pc    <= redirect ? target : redir_pc;
            state <= ST_REQ;
          end else if (redirect) begin
            redir_pc <= target;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus pushes the expected IF/ID write
// into a scoreboard queue; a monitor pops and compares on every IF/ID write.
module tb_fetch_unit;
  import mips_fetch_pkg::*;

  typedef struct packed {
    logic        clr;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        ack;
  logic [31:0] instruction;
  logic        awrite;
  logic        aclr;
  logic [31:0] id_pc_plus4;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .instruction   (instruction),
    .awrite        (awrite),
    .aclr          (aclr),
    .id_pc_plus4   (id_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory image: each word is derived from its address, so a wrong fetch
  // address shows up as a wrong instruction.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  assign imem.imem_ack   = ack;
  assign imem.imem_rdata = mem_word(imem.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards apply to the
  // following cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic deliver(input logic [31:0] a, input logic [31:0] pc4);
    exp_q.push_back('{clr: 1'b0, instr: mem_word(a), pc4: pc4});
  endtask

  task automatic bubble();
    exp_q.push_back('{clr: 1'b1, instr: 32'h0, pc4: 32'h0});
  endtask

  task automatic check_addr(input string name, input logic [31:0] a);
    #1;
    check(name, imem.imem_addr, a);
    check({name, "_req"}, 32'(imem.imem_req), 32'h1);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && awrite) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: aclr=%b instr=%h expected no write", aclr, instruction);
        end else begin
          e = exp_q.pop_front();
          check("aclr", 32'(aclr), 32'(e.clr));
          if (!e.clr) begin
            check("instruction", instruction, e.instr);
            @(posedge clk);
            #1;
            check("id_pc_plus4", id_pc_plus4, e.pc4);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_index    = 26'h0;
    ack           = 1'b0;

    // Reset state
    step();
    step();
    check("rst_req",    32'(imem.imem_req), 32'h0);
    check("rst_awrite", 32'(awrite),        32'h1);
    check("rst_aclr",   32'(aclr),          32'h1);
    check("rst_addr",   imem.imem_addr,     32'h0);
    check("rst_pc4",    id_pc_plus4,        32'h0);

    // Zero-wait memory: one instruction per cycle
    rst_n  = 1'b1;
    mon_en = 1'b1;
    ack    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_addr("seq_addr", 32'(4 * i));
      deliver(32'(4 * i), 32'(4 * i + 4));
      step();
    end

    // Ack delayed two cycles: bubbles, address held stable
    ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_addr("wait_addr", 32'hC);
      bubble();
      step();
    end
    ack = 1'b1;
    deliver(32'hC, 32'h10);
    step();

    // Stall on the ack cycle, held for three cycles
    stall = 1'b1;
    #1 check("stall_awrite0", 32'(awrite), 32'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hold_awrite0", 32'(awrite),        32'h0);
      check("hold_no_req",  32'(imem.imem_req), 32'h0);
      step();
    end
    stall = 1'b0;
    deliver(32'h10, 32'h14);
    #1 check("hold_release_no_req", 32'(imem.imem_req), 32'h0);
    step();

    // Taken branch while request outstanding: flush, discard late word
    ack           = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    bubble();
    step();
    branch_taken = 1'b0;
    check_addr("drop_addr_stable", 32'h14);
    bubble();
    step();
    ack = 1'b1;
    bubble();
    step();
    check_addr("branch_target_addr", 32'h40);
    deliver(32'h40, 32'h44);
    step();

    // Set up id_pc_plus4 = 0x1000_0008, then jump
    branch_taken  = 1'b1;
    branch_target = 32'h1000_0004;
    bubble();
    step();
    branch_taken = 1'b0;
    deliver(32'h1000_0004, 32'h1000_0008);
    step();
    jump       = 1'b1;
    jump_index = 26'h10;
    bubble();
    step();
    jump = 1'b0;
    check_addr("jump_addr", 32'h1000_0040);
    deliver(32'h1000_0040, 32'h1000_0044);
    step();

    // Branch wins over jump; flush overrides stall
    jump          = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    stall         = 1'b1;
    bubble();
    step();
    jump         = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b0;
    check_addr("branch_over_jump_addr", 32'h200);
    deliver(32'h200, 32'h204);
    step();

    // PC wrap-around
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    bubble();
    step();
    branch_taken = 1'b0;
    deliver(32'hFFFF_FFFC, 32'h0);
    step();
    check_addr("wrap_addr", 32'h0);

    // Reset pulsed mid-HOLD
    stall = 1'b1;
    step();
    #1 check("pre_rst_hold_no_req", 32'(imem.imem_req), 32'h0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_req",    32'(imem.imem_req), 32'h0);
    check("mid_rst_awrite", 32'(awrite),        32'h1);
    check("mid_rst_aclr",   32'(aclr),          32'h1);
    check("mid_rst_addr",   imem.imem_addr,     32'h0);
    check("mid_rst_pc4",    id_pc_plus4,        32'h0);
    step();
    step();
    rst_n  = 1'b1;
    stall  = 1'b0;
    mon_en = 1'b1;
    check_addr("restart_addr", 32'h0);
    deliver(32'h0, 32'h4);
    step();
    deliver(32'h4, 32'h8);
    step();

    // Quiesce: no further IF/ID writes expected
    stall = 1'b1;
    ack   = 1'b0;
    step();
    step();
    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
